// File: rtl/zmips_pkg.sv
// Shared types for the zmips boot path: loader state encoding and frame constants.
package zmips_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } boot_state_t;

    localparam logic [7:0] BOOT_MAGIC = 8'hA5;

endpackage

// File: rtl/zmips_byte_packer.sv
// Packs a byte stream MSB-first into 32-bit words; word_valid pulses the cycle after the 4th byte.
module zmips_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_byte,
    input  logic        push,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= push && (cnt == 2'd3);
            if (clear) begin
                cnt <= '0;
            end else if (push) begin
                word <= {word[23:0], data_byte};
                cnt  <= cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/zmips_boot_loader.sv
// Boot loader: parses MAGIC/LEN/data/CSUM frames, writes instruction memory, then releases the core.
// Stream handshake: a byte moves on a cycle where in_valid and in_ready are both high; nothing else consumes it.
module zmips_boot_loader
    import zmips_pkg::*;
#(
    parameter int IM_DEPTH = 4096,
    parameter int AW       = $clog2(IM_DEPTH),
    parameter int TIMEOUT  = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          cpu_rst,
    output logic          busy,
    output logic          err
);

    localparam int              IW         = $clog2(TIMEOUT + 1);
    localparam logic [16:0]     MAX_LEN    = 17'(IM_DEPTH);
    localparam logic [IW-1:0]   IDLE_LIMIT = IW'(TIMEOUT - 1);

    boot_state_t     state, state_nxt;
    logic [15:0]     len;
    logic [15:0]     len_full;
    logic [AW-1:0]   word_cnt;
    logic [1:0]      byte_idx;
    logic [7:0]      csum;
    logic [IW-1:0]   idle_cnt;
    logic            xfer;
    logic            timed_out;
    logic            last_byte;
    logic [31:0]     packed_word;
    logic            word_valid;

    assign xfer      = in_valid & in_ready;
    assign len_full  = {len[15:8], in_data};
    assign timed_out = busy && !xfer && (idle_cnt == IDLE_LIMIT);
    // The frame leaves DATA on the last data byte itself, so a CSUM byte arriving
    // while the final word is still being written is never mistaken for data.
    assign last_byte = (byte_idx == 2'd3) && (16'(word_cnt) == len - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ERROR: if (xfer && in_data == BOOT_MAGIC) state_nxt = LEN_HI;
            LEN_HI:      if (xfer) state_nxt = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if ({1'b0, len_full} > MAX_LEN) state_nxt = ERROR;
                    else if (len_full == 16'd0)     state_nxt = CSUM;
                    else                            state_nxt = DATA;
                end
            end
            DATA:        if (xfer && last_byte) state_nxt = CSUM;
            CSUM:        if (xfer) state_nxt = (in_data == csum) ? DONE : ERROR;
            DONE:        state_nxt = DONE;
            default:     state_nxt = IDLE;
        endcase
        if (timed_out) state_nxt = ERROR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len      <= '0;
            csum     <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
            idle_cnt <= '0;
        end else begin
            if (xfer || !busy) idle_cnt <= '0;
            else               idle_cnt <= idle_cnt + 1'b1;
            if (word_valid) word_cnt <= word_cnt + 1'b1;
            if (xfer) begin
                case (state)
                    IDLE, ERROR: if (in_data == BOOT_MAGIC) csum <= '0;
                    LEN_HI: begin
                        len[15:8] <= in_data;
                        csum      <= csum + in_data;
                    end
                    LEN_LO: begin
                        len[7:0]  <= in_data;
                        csum      <= csum + in_data;
                        word_cnt  <= '0;
                        byte_idx  <= '0;
                    end
                    DATA: begin
                        csum      <= csum + in_data;
                        byte_idx  <= byte_idx + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    zmips_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .data_byte  (in_data),
        .push       (xfer && state == DATA),
        .clear      (state != DATA),
        .word       (packed_word),
        .word_valid (word_valid)
    );

    assign in_ready = (state != DONE);
    assign cpu_rst  = (state != DONE);
    assign err      = (state == ERROR);
    assign busy     = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) || (state == CSUM);
    assign im_we    = word_valid;
    assign im_addr  = word_cnt;
    assign im_wdata = packed_word;

endmodule

// File: tb/tb_zmips_boot_loader.sv
// Directed bench for zmips_boot_loader: frame-level model checked every cycle plus literal pins.
module tb_zmips_boot_loader;

    localparam int IM_DEPTH = 4096;
    localparam int AW       = 12;
    localparam int TIMEOUT  = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          err;

    int tests = 0;
    int fails = 0;

    zmips_boot_loader #(.IM_DEPTH(IM_DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .err      (err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checks ----------------
    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // Tracks the bytes of the current frame and derives status from them.
    logic              m_active, m_done, m_err, pend_we;
    int                idle;
    logic [7:0]        fb[$];
    logic [AW+31:0]    exp_q[$];
    logic [31:0]       got_mem [0:IM_DEPTH-1];
    int                we_cnt;

    task automatic model_reset();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        pend_we  = 1'b0;
        idle     = 0;
        fb.delete();
        exp_q.delete();
    endtask

    task automatic model_step(input logic xfer, input logic [7:0] b);
        int n, len, sum, k;
        pend_we = 1'b0;
        if (!xfer) begin
            if (m_active) begin
                idle++;
                if (idle >= TIMEOUT) begin
                    m_active = 1'b0;
                    m_err    = 1'b1;
                end
            end
            return;
        end
        idle = 0;
        if (!m_active) begin
            if (b == 8'hA5) begin
                m_active = 1'b1;
                m_err    = 1'b0;
                fb.delete();
            end
            return;
        end
        fb.push_back(b);
        n = fb.size();
        if (n < 2) return;
        len = int'({fb[0], fb[1]});
        if (n == 2 && len > IM_DEPTH) begin
            m_active = 1'b0;
            m_err    = 1'b1;
            return;
        end
        if (n == 3 + 4 * len) begin
            sum = 0;
            for (int i = 0; i < n - 1; i++) sum += int'(fb[i]);
            if (sum[7:0] == b) m_done = 1'b1;
            else               m_err  = 1'b1;
            m_active = 1'b0;
            return;
        end
        if (n >= 6 && ((n - 2) % 4) == 0) begin
            k = (n - 2) / 4;
            exp_q.push_back({AW'(k - 1), fb[n-4], fb[n-3], fb[n-2], fb[n-1]});
            pend_we = 1'b1;
        end
    endtask

    // Compare on the falling edge, then advance the model for the next rising edge.
    always @(negedge clk) begin
        logic [AW+31:0] e;
        if (rst) model_reset();
        chk1("in_ready", in_ready, !m_done);
        chk1("cpu_rst", cpu_rst, !m_done);
        chk1("busy", busy, m_active);
        chk1("err", err, m_err);
        chk1("im_we", im_we, pend_we);
        if (im_we) begin
            got_mem[im_addr] = im_wdata;
            we_cnt++;
        end
        if (pend_we) begin
            e = exp_q.pop_front();
            chk32("im_addr", 32'(im_addr), 32'(e[AW+31:32]));
            chk32("im_wdata", im_wdata, e[31:0]);
        end
        if (!rst) model_step(in_valid && !m_done, in_data);
    end

    // ---------------- driver ----------------
    logic [7:0] seq[$];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick(1);
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic send_seq(input bit gappy);
        foreach (seq[i]) begin
            send_byte(seq[i]);
            if (gappy) tick(1);
        end
        seq.delete();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick(2);
        rst      = 1'b0;
        tick(1);
        we_cnt   = 0;
        for (int i = 0; i < 4; i++) got_mem[i] = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        we_cnt   = 0;
        model_reset();
        tick(2);
        chk1("rst in_ready", in_ready, 1'b1);
        chk1("rst cpu_rst", cpu_rst, 1'b1);
        chk1("rst im_we", im_we, 1'b0);
        chk32("rst im_addr", 32'(im_addr), 32'h0);
        chk32("rst im_wdata", im_wdata, 32'h0);
        chk1("rst busy", busy, 1'b0);
        chk1("rst err", err, 1'b0);
        do_reset();

        // 1: single word; csum = 00+01+12+34+56+78 mod 256 = 15
        seq = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h15};
        send_seq(1'b0);
        chk1("t1 cpu_rst low", cpu_rst, 1'b0);
        chk1("t1 err", err, 1'b0);
        chk1("t1 in_ready", in_ready, 1'b0);
        chk32("t1 writes", 32'(we_cnt), 32'd1);
        chk32("t1 word0", got_mem[0], 32'h12345678);

        // 2: two words with in_valid toggling; csum = E4
        do_reset();
        seq = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hE4};
        send_seq(1'b1);
        chk1("t2 cpu_rst low", cpu_rst, 1'b0);
        chk32("t2 writes", 32'(we_cnt), 32'd2);
        chk32("t2 word0", got_mem[0], 32'h11223344);
        chk32("t2 word1", got_mem[1], 32'hDEADBEEF);

        // 3: bad csum, then the good frame
        do_reset();
        seq = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
        send_seq(1'b0);
        chk1("t3 err set", err, 1'b1);
        chk1("t3 cpu_rst held", cpu_rst, 1'b1);
        seq = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h15};
        send_seq(1'b0);
        chk1("t3 err cleared", err, 1'b0);
        chk1("t3 cpu_rst low", cpu_rst, 1'b0);

        // 4: empty frame, oversize length, and the largest legal length
        do_reset();
        seq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_seq(1'b0);
        chk1("t4 len0 done", cpu_rst, 1'b0);
        chk32("t4 len0 writes", 32'(we_cnt), 32'd0);
        do_reset();
        seq = '{8'hA5, 8'h10, 8'h01};
        send_seq(1'b0);
        chk1("t4 oversize err", err, 1'b1);
        chk1("t4 oversize busy", busy, 1'b0);
        do_reset();
        seq = '{8'hA5, 8'h10, 8'h00};
        send_seq(1'b0);
        chk1("t4 maxlen busy", busy, 1'b1);
        chk1("t4 maxlen err", err, 1'b0);

        // 5: noise dropped; timeout fires exactly TIMEOUT cycles after LEN_LO
        do_reset();
        seq = '{8'h00, 8'hFF, 8'h5A};
        send_seq(1'b0);
        chk1("t5 noise busy", busy, 1'b0);
        chk1("t5 noise err", err, 1'b0);
        seq = '{8'hA5, 8'h00, 8'h01};
        send_seq(1'b0);
        tick(TIMEOUT - 1);
        chk1("t5 before timeout", err, 1'b0);
        tick(1);
        chk1("t5 at timeout", err, 1'b1);
        chk1("t5 timeout cpu_rst", cpu_rst, 1'b1);

        // 6: async reset mid-word, then a realigned full frame
        do_reset();
        seq = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
        send_seq(1'b0);
        rst = 1'b1;
        #1;
        chk1("t6 rst busy", busy, 1'b0);
        chk1("t6 rst im_we", im_we, 1'b0);
        chk1("t6 rst cpu_rst", cpu_rst, 1'b1);
        tick(1);
        rst = 1'b0;
        tick(1);
        we_cnt = 0;
        seq = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hE4};
        send_seq(1'b0);
        chk1("t6 done", cpu_rst, 1'b0);
        chk32("t6 word0", got_mem[0], 32'h11223344);
        chk32("t6 word1", got_mem[1], 32'hDEADBEEF);

        tick(2);
        chk32("exp_q drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
